// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master core.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/spi_clk_div.sv
// Tick generator for the SPI core: one tick every DIV cycles while enabled.
// The first tick lands on the cycle right after a clear.
module spi_clk_div #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == '0);

endmodule

// File: rtl/spi_master_core.sv
// Mode-0 SPI master, one chip select, WIDTH-bit full-duplex transfers.
// Define SPI_LSB_FIRST_EN to shift LSB first; default is MSB first.
module spi_master_core
    import spi_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DIV   = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] DOUT,
    output logic [WIDTH-1:0] DIN,
    output logic             SCK,
    output logic             CS,
    output logic             MOSI,
    input  logic             MISO,
    output logic             BUSY,
    output logic             DONE
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] tx;
    logic [WIDTH-1:0] rx;
    logic [WIDTH-1:0] tx_next;
    logic [BW-1:0]    bit_cnt;
    logic             tick;
    logic             accept;

`ifdef SPI_LSB_FIRST_EN
    function automatic logic [WIDTH-1:0] shift_tx(input logic [WIDTH-1:0] v);
        return {1'b0, v[WIDTH-1:1]};
    endfunction

    function automatic logic out_bit(input logic [WIDTH-1:0] v);
        return v[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_rx(input logic [WIDTH-1:0] r, input logic b);
        return {b, r[WIDTH-1:1]};
    endfunction
`else
    function automatic logic [WIDTH-1:0] shift_tx(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], 1'b0};
    endfunction

    function automatic logic out_bit(input logic [WIDTH-1:0] v);
        return v[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] shift_rx(input logic [WIDTH-1:0] r, input logic b);
        return {r[WIDTH-2:0], b};
    endfunction
`endif

    assign accept  = (state == IDLE) && START;
    assign tx_next = shift_tx(tx);

    spi_clk_div #(.DIV(DIV)) u_clk_div (
        .clk  (CLK),
        .rst_n(RST_N),
        .clr  (accept),
        .en   (state != IDLE),
        .tick (tick)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= IDLE;
            tx      <= '0;
            rx      <= '0;
            bit_cnt <= '0;
            SCK     <= 1'b0;
            CS      <= 1'b1;
            MOSI    <= 1'b0;
            DIN     <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        tx      <= DOUT;
                        CS      <= 1'b0;
                        MOSI    <= out_bit(DOUT);
                        BUSY    <= 1'b1;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!SCK) begin
                            SCK <= 1'b1;
                            rx  <= shift_rx(rx, MISO);
                        end else begin
                            // MOSI only moves on the falling edge, giving the slave a full half-period of setup.
                            SCK <= 1'b0;
                            if (bit_cnt < LAST_BIT) begin
                                tx      <= tx_next;
                                MOSI    <= out_bit(tx_next);
                                bit_cnt <= bit_cnt + 1'b1;
                            end else begin
                                state <= HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        CS    <= 1'b1;
                        DIN   <= rx;
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        MOSI  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_core.sv
// Bench for spi_master_core: a DIV=1 and a DIV=3 instance against a slave/bus model.
module tb_spi_master_core;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         start1 = 1'b0, start3 = 1'b0;
    logic [W-1:0] dout1 = '0, dout3 = '0;
    logic [W-1:0] din1, din3;
    logic         sck1, sck3, cs1, cs3, mosi1, mosi3, miso1, miso3;
    logic         busy1, busy3, done1, done3;

    logic         sel3 = 1'b0;
    logic         lb_r = 1'b0;
    logic         slave_bit = 1'b0;
    logic         m_sck, m_cs, m_mosi, m_busy, m_done;
    logic [W-1:0] m_din;

    int pass_cnt = 0;
    int total_cnt = 0;

    int           rises, falls, phase_err, cs_low, done_cnt, done_edge;
    logic [W-1:0] done_din, stream;

    always #5 CLK = ~CLK;

    assign miso1  = lb_r ? mosi1 : slave_bit;
    assign miso3  = lb_r ? mosi3 : slave_bit;
    assign m_sck  = sel3 ? sck3  : sck1;
    assign m_cs   = sel3 ? cs3   : cs1;
    assign m_mosi = sel3 ? mosi3 : mosi1;
    assign m_busy = sel3 ? busy3 : busy1;
    assign m_done = sel3 ? done3 : done1;
    assign m_din  = sel3 ? din3  : din1;

    spi_master_core #(.WIDTH(W), .DIV(1)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(start1), .DOUT(dout1), .DIN(din1),
        .SCK(sck1), .CS(cs1), .MOSI(mosi1), .MISO(miso1), .BUSY(busy1), .DONE(done1)
    );

    spi_master_core #(.WIDTH(W), .DIV(3)) dut3 (
        .CLK(CLK), .RST_N(RST_N), .START(start3), .DOUT(dout3), .DIN(din3),
        .SCK(sck3), .CS(cs3), .MOSI(mosi3), .MISO(miso3), .BUSY(busy3), .DONE(done3)
    );

    // Bit the slave presents for the k-th SCK rise of a transfer.
    function automatic logic bit_of(input logic [W-1:0] w, input int k);
        logic [2:0] idx;
        if (k >= W) return 1'b0;
        idx = 3'(k);
`ifdef SPI_LSB_FIRST_EN
        return w[idx];
`else
        return w[3'd7 - idx];
`endif
    endfunction

    // Word formed by the MOSI bits in wire order, first bit in the MSB.
    function automatic logic [W-1:0] exp_stream(input logic [W-1:0] d);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) r = {r[W-2:0], bit_of(d, i)};
        return r;
    endfunction

    task automatic drive_start(input logic use3, input logic s, input logic [W-1:0] d);
        if (use3) begin
            start3 = s;
            dout3  = d;
        end else begin
            start1 = s;
            dout1  = d;
        end
    endtask

    // Runs one transfer and records what happened on the bus, edge numbers relative to acceptance.
    task automatic run_xfer(input logic [W-1:0] dout, input logic [W-1:0] sword, input logic lb,
                            input logic use3, input int inject_at);
        int   div;
        logic prev;
        div = use3 ? 3 : 1;
        sel3 = use3; lb_r = lb;
        rises = 0; falls = 0; phase_err = 0; cs_low = 0;
        done_cnt = 0; done_edge = -1; done_din = '0; stream = '0; prev = 1'b0;
        slave_bit = bit_of(sword, 0);
        @(negedge CLK);
        drive_start(use3, 1'b1, dout);
        @(posedge CLK); #1;
        drive_start(use3, 1'b0, ~dout);
        for (int e = 0; e < 250; e++) begin
            if (e > 0) begin
                @(posedge CLK); #1;
            end
            if (!m_cs) cs_low++;
            if (m_sck && !prev) begin
                stream = {stream[W-2:0], m_mosi};
                if (e != 1 + 2 * div * rises) phase_err++;
                rises++;
                slave_bit = bit_of(sword, rises);
            end
            if (!m_sck && prev) begin
                if (e != 1 + div + 2 * div * falls) phase_err++;
                falls++;
            end
            if (m_done) begin
                done_cnt++;
                done_edge = e;
                done_din  = m_din;
            end
            prev = m_sck;
            if (e == inject_at - 1) drive_start(use3, 1'b1, 8'hFF);
            if (e == inject_at)     drive_start(use3, 1'b0, 8'hFF);
            if (done_cnt > 0 && e >= done_edge + 4) break;
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        total_cnt++;
        if ({cs1, sck1, mosi1, busy1, done1} !== 5'b10000) $display("FAIL reset_ctl1 got=%b want=10000", {cs1, sck1, mosi1, busy1, done1});
        else pass_cnt++;
        total_cnt++;
        if (din1 !== 8'h00) $display("FAIL reset_din1 got=%h want=00", din1);
        else pass_cnt++;
        total_cnt++;
        if ({cs3, sck3, mosi3, busy3, done3} !== 5'b10000) $display("FAIL reset_ctl3 got=%b want=10000", {cs3, sck3, mosi3, busy3, done3});
        else pass_cnt++;
        total_cnt++;
        if (din3 !== 8'h00) $display("FAIL reset_din3 got=%h want=00", din3);
        else pass_cnt++;
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic test_reset_mid();
        int   r;
        int   dones;
        logic prev;
        sel3 = 1'b0; lb_r = 1'b0; slave_bit = 1'b1;
        r = 0; prev = 1'b0; dones = 0;
        @(negedge CLK);
        drive_start(1'b0, 1'b1, 8'h56);
        @(posedge CLK); #1;
        drive_start(1'b0, 1'b0, 8'h00);
        for (int e = 0; e < 60 && r < 4; e++) begin
            @(posedge CLK); #1;
            if (sck1 && !prev) r++;
            prev = sck1;
        end
        total_cnt++;
        if (r != 4) $display("FAIL rstmid_rises got=%0d want=4", r);
        else pass_cnt++;
        RST_N = 1'b0;
        @(posedge CLK); #1;
        total_cnt++;
        if ({cs1, sck1, busy1, done1} !== 4'b1000) $display("FAIL rstmid_ctl got=%b want=1000", {cs1, sck1, busy1, done1});
        else pass_cnt++;
        total_cnt++;
        if (din1 !== 8'h00) $display("FAIL rstmid_din got=%h want=00", din1);
        else pass_cnt++;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        for (int e = 0; e < 25; e++) begin
            @(posedge CLK); #1;
            if (done1 || !cs1) dones++;
        end
        total_cnt++;
        if (dones != 0) $display("FAIL rstmid_after got=%0d activity cycles want=0", dones);
        else pass_cnt++;
    endtask

    task automatic check_xfer(input string tag, input logic [W-1:0] dout, input logic [W-1:0] want_din,
                              input int want_edge);
        total_cnt++;
        if (stream !== exp_stream(dout)) $display("FAIL %s_mosi got=%h want=%h", tag, stream, exp_stream(dout));
        else pass_cnt++;
        total_cnt++;
        if (done_din !== want_din) $display("FAIL %s_din got=%h want=%h", tag, done_din, want_din);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt != 1 || done_edge != want_edge) $display("FAIL %s_done got=%0d@%0d want=1@%0d", tag, done_cnt, done_edge, want_edge);
        else pass_cnt++;
        total_cnt++;
        if (rises != W || phase_err != 0) $display("FAIL %s_sck got=%0d rises %0d phase errs want=8 0", tag, rises, phase_err);
        else pass_cnt++;
        total_cnt++;
        if (cs_low != want_edge || m_cs !== 1'b1 || m_busy !== 1'b0) $display("FAIL %s_cs got=%0d low cycles want=%0d", tag, cs_low, want_edge);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        run_xfer(8'h56, 8'h34, 1'b0, 1'b0, -10);
        check_xfer("basic", 8'h56, 8'h34, 17);
    endtask

    task automatic test_random();
        logic [W-1:0] d, s;
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            s = 8'($urandom);
            run_xfer(d, s, 1'b0, 1'b0, -10);
            check_xfer("rand", d, s, 17);
        end
    endtask

    task automatic test_ignore_start();
        run_xfer(8'h56, 8'h9A, 1'b0, 1'b0, 5);
        check_xfer("ignore", 8'h56, 8'h9A, 17);
    endtask

    task automatic test_back_to_back();
        int           d1, d2, gap;
        logic [W-1:0] v1, v2;
        sel3 = 1'b0; lb_r = 1'b1;
        d1 = -1; d2 = -1; gap = 0; v1 = '0; v2 = '0;
        @(negedge CLK);
        drive_start(1'b0, 1'b1, 8'hA5);
        @(posedge CLK); #1;
        dout1 = 8'h3C;
        for (int e = 0; e < 120 && d2 < 0; e++) begin
            if (e > 0) begin
                @(posedge CLK); #1;
            end
            if (d1 >= 0 && cs1) gap++;
            if (done1) begin
                if (d1 < 0) begin
                    d1 = e; v1 = din1;
                end else begin
                    d2 = e; v2 = din1;
                    start1 = 1'b0;
                end
            end
        end
        start1 = 1'b0;
        total_cnt++;
        if (d1 != 17 || v1 !== 8'hA5) $display("FAIL b2b_first got=%h@%0d want=a5@17", v1, d1);
        else pass_cnt++;
        total_cnt++;
        if (d2 != 35 || v2 !== 8'h3C) $display("FAIL b2b_second got=%h@%0d want=3c@35", v2, d2);
        else pass_cnt++;
        total_cnt++;
        if (gap < 1) $display("FAIL b2b_gap got=%0d want>=1", gap);
        else pass_cnt++;
        repeat (3) @(posedge CLK);
        #1;
        total_cnt++;
        if (busy1 !== 1'b0 || cs1 !== 1'b1) $display("FAIL b2b_idle got=%b%b want=01", busy1, cs1);
        else pass_cnt++;
    endtask

    task automatic test_div3();
        logic [W-1:0] d, s;
        run_xfer(8'h56, 8'h34, 1'b0, 1'b1, -10);
        check_xfer("div3", 8'h56, 8'h34, 49);
        for (int i = 0; i < 2; i++) begin
            d = 8'($urandom);
            s = 8'($urandom);
            run_xfer(d, s, 1'b0, 1'b1, -10);
            check_xfer("div3rand", d, s, 49);
        end
    endtask

    task automatic test_loopback();
        logic [W-1:0] d;
        run_xfer(8'h01, 8'h00, 1'b1, 1'b0, -10);
        check_xfer("loop01", 8'h01, 8'h01, 17);
        d = 8'($urandom);
        run_xfer(d, 8'h00, 1'b1, 1'b0, -10);
        check_xfer("looprand", d, d, 17);
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_basic();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_div3();
        test_loopback();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
